secure_alu_pipe: RTL
====================

// Module: secure_alu_pipe
// PURPOSE
//   Parametrised, pipelined successor of the 8-bit always-encrypted ALU. Each accepted
//   transaction carries its own key. Encrypt mode: ALU result -> OTP XOR -> R-round
//   nibble-S-box SPN. Decrypt mode: inverse SPN on in_a, used for host-side readback.
//   Valid/ready on both sides, one transaction per cycle, full backpressure.
//   Bit-exact with the existing 8-bit encoding at W=8, ROUNDS=2.
// PARAMETERS
//   W       8   datapath/key width; multiple of 8, >= 8
//   ROUNDS  2   SPN rounds, 1..8; one pipeline stage per round
// PORTS
//   clk         in   1   single clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   in_valid    in   1   input transaction valid
//   in_ready    out  1   block can accept (comb.)
//   in_a        in   W   operand A (ciphertext when in_dec=1)
//   in_b        in   W   operand B (ignored when in_dec=1)
//   in_op       in   4   opcode (ignored when in_dec=1)
//   in_key      in   W   per-transaction key
//   in_dec      in   1   0 = ALU+encrypt, 1 = decrypt in_a
//   out_valid   out  1   result valid
//   out_ready   in   1   downstream accepts result
//   out_data    out  W   ciphertext (enc) or plaintext (dec)
//   out_op_err  out  1   undefined opcode in the enc transaction; always 0 for dec
//   busy        out  1   any pipeline stage holds a valid transaction
// BEHAVIOUR
//   - Reset, async assert: every stage valid=0 and data/key/err regs=0.
//     Outputs: out_valid=0, out_data=0, out_op_err=0, busy=0, in_ready=1.
//     Reset mid-operation drops all in-flight transactions; none are replayed.
//   - Pipeline has ROUNDS+1 register stages; latency is ROUNDS+1 cycles from accept
//     (in_valid&in_ready) to out_valid with no stall.
//   - Global advance: adv = !out_valid | out_ready; in_ready = adv.
//     All stages shift together on adv; bubbles propagate as valid=0.
//     When adv=0 every stage holds, out_data is stable, and no input is accepted.
//   - Accept and output pop in the same cycle is legal, giving sustained throughput of
//     1/cycle.
//   - Stage 0, enc: s = alu(a,b,op) ^ key ^ k0, with k0 = key.
//     Stage 0, dec: s = a.
//   - ALU (W-bit, wrap modulo 2^W, carries discarded):
//     0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A+1, 7 A-1, 8 A<<1, 9 A>>1,
//     A MUL (low W bits), C PASS A, D PASS B.
//     Any other opcode gives result 0 and sets err=1; err travels with the transaction.
//   - Round keys, r=1..ROUNDS:
//     odd r:  k_r = {key[W/2-1:0], key[W-1:W/2]}
//     even r: k_r = key ^ {W/8{8'h3C}}
//   - Enc stage r: s = perm(sbox(s)) ^ k_r.
//     Dec stage j=1..ROUNDS uses r = ROUNDS+1-j: s = isbox(iperm(s ^ k_r)).
//   - sbox: 4-bit table C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2, applied to every nibble.
//     isbox is its inverse.
//   - perm: for j < W/2, out[W-1-j] = in[2j] and out[W/2-1-j] = in[2j+1].
//     iperm is its inverse.
//   - Key and mode are latched per stage with the data; changing in_key never affects
//     in-flight transactions.
//   - Round-trip: dec(enc(PASS A, a, k), k) = a for every a, k.
// STRUCTURE
//   - Package secure_alu_pkg: opcode localparams, SBOX/ISBOX tables,
//     round constant 8'h3C, functions sbox_w/isbox_w/perm_w/iperm_w (width-generic).
//   - Sub-module secure_spn_stage (params W, RIDX): one registered round with
//     valid/dec/err/key carry and hold-on-!adv.
//     Top instantiates ROUNDS of these in a generate loop after the ALU stage.
// TESTING
//   1. W=8,R=2: a=05,b=03,op=0,key=00,enc, out_ready=1
//      -> after 3 cycles out_data=63, out_op_err=0.
//   2. Same key/op; op=B, then E, then F
//      -> out_op_err=1 on each, with out_data = encryption of 00.
//   3. Random a,key, enc PASS A, then feed that out_data as dec with the same key
//      -> plaintext = a; 1000 vectors each at W=8,16,32 and R=1,2,5.
//   4. 4-deep burst, out_ready=0 for 5 cycles
//      -> in_ready=0, out_data held stable, no loss or duplication; on release,
//         results emerge in order at 1/cycle.
//   5. Back-to-back stream with out_ready toggling every cycle
//      -> every accepted transaction is output exactly once, in order.
//   6. Assert rst with 3 transactions in flight
//      -> out_valid=0 and busy=0 immediately (async); in_ready=1;
//         the first post-reset transaction has latency ROUNDS+1.

Source files
------------

// File: rtl/secure_alu_pkg.sv
// rtl/secure_alu_pkg.sv - opcodes, S-box tables and width-generic SPN helpers
package secure_alu_pkg;

    // Widest datapath the helper functions can carry; callers truncate to W.
    localparam int MAXW = 128;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOTA  = 4'h5;
    localparam logic [3:0] OP_INC   = 4'h6;
    localparam logic [3:0] OP_DEC   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_MUL   = 4'hA;
    localparam logic [3:0] OP_PASSA = 4'hC;
    localparam logic [3:0] OP_PASSB = 4'hD;

    // Nibble n of each table sits at bits [4n+3:4n].
    localparam logic [63:0] SBOX  = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] ISBOX = 64'hA970_364B_D21C_8FE5;

    localparam logic [7:0] RC = 8'h3C;

    function automatic logic [MAXW-1:0] sbox_w(input logic [MAXW-1:0] x);
        logic [MAXW-1:0] y;
        y = '0;
        for (int n = 0; n < MAXW/4; n++) begin
            y[4*n +: 4] = SBOX[{x[4*n +: 4], 2'b00} +: 4];
        end
        return y;
    endfunction

    function automatic logic [MAXW-1:0] isbox_w(input logic [MAXW-1:0] x);
        logic [MAXW-1:0] y;
        y = '0;
        for (int n = 0; n < MAXW/4; n++) begin
            y[4*n +: 4] = ISBOX[{x[4*n +: 4], 2'b00} +: 4];
        end
        return y;
    endfunction

    // Even input bits fill the upper half (reversed), odd bits the lower half.
    function automatic logic [MAXW-1:0] perm_w(input logic [MAXW-1:0] x, input int w);
        logic [MAXW-1:0] y;
        y = '0;
        for (int j = 0; j < MAXW/2; j++) begin
            if (j < w/2) begin
                y[w-1-j]   = x[2*j];
                y[w/2-1-j] = x[2*j+1];
            end
        end
        return y;
    endfunction

    function automatic logic [MAXW-1:0] iperm_w(input logic [MAXW-1:0] x, input int w);
        logic [MAXW-1:0] y;
        y = '0;
        for (int j = 0; j < MAXW/2; j++) begin
            if (j < w/2) begin
                y[2*j]   = x[w-1-j];
                y[2*j+1] = x[w/2-1-j];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/secure_spn_stage.sv
// rtl/secure_spn_stage.sv - one registered SPN round carrying valid/dec/err/key
module secure_spn_stage
    import secure_alu_pkg::*;
#(
    parameter int W      = 8,
    parameter int ROUNDS = 2,
    parameter int RIDX   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         prev_valid,
    input  logic         prev_dec,
    input  logic         prev_err,
    input  logic [W-1:0] prev_key,
    input  logic [W-1:0] prev_data,
    output logic         valid,
    output logic         dec,
    output logic         err,
    output logic [W-1:0] key,
    output logic [W-1:0] data
);

    // Decryption walks the rounds backwards, so this slot undoes the mirrored round.
    localparam int DIDX = ROUNDS + 1 - RIDX;

    function automatic logic [W-1:0] round_key(input logic [W-1:0] k, input int r);
        return (r % 2 == 1) ? {k[W/2-1:0], k[W-1:W/2]} : (k ^ {(W/8){RC}});
    endfunction

    logic [W-1:0] enc_key;
    logic [W-1:0] dec_key;
    logic [W-1:0] enc_next;
    logic [W-1:0] dec_next;

    assign enc_key  = round_key(prev_key, RIDX);
    assign dec_key  = round_key(prev_key, DIDX);
    assign enc_next = W'(perm_w(sbox_w(MAXW'(prev_data)), W)) ^ enc_key;
    assign dec_next = W'(isbox_w(iperm_w(MAXW'(prev_data ^ dec_key), W)));

    // Round register: shifts on the global advance, otherwise holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dec   <= 1'b0;
            err   <= 1'b0;
            key   <= '0;
            data  <= '0;
        end else if (adv) begin
            valid <= prev_valid;
            dec   <= prev_dec;
            err   <= prev_err;
            key   <= prev_key;
            data  <= prev_dec ? dec_next : enc_next;
        end
    end

endmodule

// File: rtl/secure_alu_pipe.sv
// rtl/secure_alu_pipe.sv - pipelined ALU with per-transaction SPN encrypt/decrypt
module secure_alu_pipe
    import secure_alu_pkg::*;
#(
    parameter int W      = 8,
    parameter int ROUNDS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [3:0]   in_op,
    input  logic [W-1:0] in_key,
    input  logic         in_dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_op_err,
    output logic         busy
);

    logic            adv;
    logic [W-1:0]    alu_res;
    logic            alu_err;
    logic [W-1:0]    k0;

    logic            s0_valid;
    logic            s0_dec;
    logic            s0_err;
    logic [W-1:0]    s0_key;
    logic [W-1:0]    s0_data;

    logic [ROUNDS:0] v_s;
    logic [ROUNDS:0] dec_s;
    logic [ROUNDS:0] err_s;
    logic [W-1:0]    key_s  [ROUNDS+1];
    logic [W-1:0]    data_s [ROUNDS+1];

    // Whole pipe moves as one; a full output that is not taken freezes it.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Whitening key equals the transaction key, keeping the legacy 8-bit encoding.
    assign k0 = in_key;

    // Combinational ALU; unknown opcodes yield zero and flag the transaction.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (in_op)
            OP_ADD:   alu_res = in_a + in_b;
            OP_SUB:   alu_res = in_a - in_b;
            OP_AND:   alu_res = in_a & in_b;
            OP_OR:    alu_res = in_a | in_b;
            OP_XOR:   alu_res = in_a ^ in_b;
            OP_NOTA:  alu_res = ~in_a;
            OP_INC:   alu_res = in_a + W'(1);
            OP_DEC:   alu_res = in_a - W'(1);
            OP_SHL:   alu_res = in_a << 1;
            OP_SHR:   alu_res = in_a >> 1;
            OP_MUL:   alu_res = in_a * in_b;
            OP_PASSA: alu_res = in_a;
            OP_PASSB: alu_res = in_b;
            default:  alu_err = 1'b1;
        endcase
    end

    // Stage 0: capture the ALU+whitening result, or the raw ciphertext for decrypt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_dec   <= 1'b0;
            s0_err   <= 1'b0;
            s0_key   <= '0;
            s0_data  <= '0;
        end else if (adv) begin
            s0_valid <= in_valid;
            s0_dec   <= in_dec;
            s0_err   <= !in_dec && alu_err;
            s0_key   <= in_key;
            s0_data  <= in_dec ? in_a : (alu_res ^ in_key ^ k0);
        end
    end

    assign v_s[0]    = s0_valid;
    assign dec_s[0]  = s0_dec;
    assign err_s[0]  = s0_err;
    assign key_s[0]  = s0_key;
    assign data_s[0] = s0_data;

    for (genvar i = 0; i < ROUNDS; i++) begin : g_round
        secure_spn_stage #(
            .W      (W),
            .ROUNDS (ROUNDS),
            .RIDX   (i + 1)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv),
            .prev_valid (v_s[i]),
            .prev_dec   (dec_s[i]),
            .prev_err   (err_s[i]),
            .prev_key   (key_s[i]),
            .prev_data  (data_s[i]),
            .valid      (v_s[i+1]),
            .dec        (dec_s[i+1]),
            .err        (err_s[i+1]),
            .key        (key_s[i+1]),
            .data       (data_s[i+1])
        );
    end

    assign out_valid  = v_s[ROUNDS];
    assign out_data   = data_s[ROUNDS];
    assign out_op_err = err_s[ROUNDS];
    assign busy       = |v_s;

endmodule
